// File: rtl/kf8088_bus_cycle_generator.sv
// ---------------------------------------------------------------------------
// kf8088_bus_cycle_generator
//
// CPU-side bus sequencer. It takes one request at a time from the core and
// runs an 8088-style Ti/T1/T2/T3/Tw/T4 machine cycle against the bus. It
// drives S2..S0 status, the address and the write data, samples READY and
// captures read data. processor_status feeds an 8288-like bus controller.
//
// The design runs on the fast system clock. cpu_clock is only a level, and
// its edges are found against a registered copy:
//   pos (cpu_clock rose)  -> status/address launch and release, READY sample
//   neg (cpu_clock fell)  -> T-state advance, write data, read capture, done
//
// Ports
//   clock, reset          system clock (posedge), async active-high reset
//   cpu_clock             CPU clock level
//   req_valid/req_ready   request handshake, accepted when both are high
//   req_status            cycle type, S2..S0 encoding (111 = no bus cycle)
//   req_address/req_wdata request address and write data
//   done                  one-clock pulse when a request completes
//   rdata                 read data, valid with done for read/INTA types
//   bus_timeout           pulses with done when the wait limit ended a cycle
//   processor_status      S2..S0 to the bus controller, 111 = passive
//   address               bus address, held for the whole cycle
//   data_out/_enable      write data and its drive enable
//   data_in               read data from the bus
//   ready                 synchronised READY, 1 ends wait states
// ---------------------------------------------------------------------------
module kf8088_bus_cycle_generator #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_WAIT      = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_clock,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_status,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     bus_timeout,
    output logic [2:0]               processor_status,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_enable,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     ready
);

    localparam logic [2:0] S_PASSIVE = 3'b111;
    localparam logic [2:0] S_HALT    = 3'b011;

    // Wide enough to hold MAX_WAIT and one more; saturates at all ones.
    localparam int TW_W = $clog2(MAX_WAIT + 2);

    typedef enum logic [2:0] {
        ST_TI,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic                     cpu_clock_q;
    state_t                   state_q,        state_d;
    logic                     cmd_valid_q,    cmd_valid_d;
    logic [2:0]               cmd_status_q,   cmd_status_d;
    logic [ADDRESS_WIDTH-1:0] cmd_address_q,  cmd_address_d;
    logic [DATA_WIDTH-1:0]    cmd_wdata_q,    cmd_wdata_d;
    logic [2:0]               cyc_status_q,   cyc_status_d;
    logic [2:0]               status_q,       status_d;
    logic [ADDRESS_WIDTH-1:0] address_q,      address_d;
    logic [DATA_WIDTH-1:0]    data_out_q,     data_out_d;
    logic                     doe_q,          doe_d;
    logic [DATA_WIDTH-1:0]    rdata_q,        rdata_d;
    logic                     done_q,         done_d;
    logic                     bus_timeout_q,  bus_timeout_d;
    logic                     go_q,           go_d;
    logic                     timeout_q,      timeout_d;
    logic [TW_W-1:0]          tw_count_q,     tw_count_d;

    logic pos;
    logic neg;
    logic accept;
    logic go_now;
    logic forced;
    logic tw_limit;
    logic cyc_read;
    logic cyc_write;
    logic cyc_halt;

    // Cycle type of the cycle currently on the bus (copied at launch, so a
    // request accepted during T4 cannot disturb the finishing cycle).
    assign cyc_read  = (cyc_status_q[1] == 1'b0);
    assign cyc_write = (cyc_status_q[1:0] == 2'b10);
    assign cyc_halt  = (cyc_status_q == S_HALT);

    // Wait-state limit; with MAX_WAIT = 0 waits are unlimited.
    generate
        if (MAX_WAIT != 0) begin : g_wait_limit
            assign tw_limit = (tw_count_q >= TW_W'(MAX_WAIT));
        end else begin : g_no_wait_limit
            assign tw_limit = 1'b0;
        end
    endgenerate

    assign req_ready = ~cmd_valid_q & ((state_q == ST_TI) | (state_q == ST_T4));

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        pos           = cpu_clock & ~cpu_clock_q;
        neg           = ~cpu_clock & cpu_clock_q;
        accept        = req_valid & req_ready;
        go_now        = 1'b0;
        forced        = 1'b0;

        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_status_d  = cmd_status_q;
        cmd_address_d = cmd_address_q;
        cmd_wdata_d   = cmd_wdata_q;
        cyc_status_d  = cyc_status_q;
        status_d      = status_q;
        address_d     = address_q;
        data_out_d    = data_out_q;
        doe_d         = doe_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        bus_timeout_d = 1'b0;
        go_d          = go_q;
        timeout_d     = timeout_q;
        tw_count_d    = tw_count_q;

        // Request acceptance. A passive-status request has no bus cycle and
        // completes immediately.
        if (accept) begin
            if (req_status == S_PASSIVE) begin
                done_d = 1'b1;
            end else begin
                cmd_valid_d   = 1'b1;
                cmd_status_d  = req_status;
                cmd_address_d = req_address;
                cmd_wdata_d   = req_wdata;
            end
        end

        if (pos) begin
            // Launch: status and address go out half a CPU clock before T1.
            if (cmd_valid_q && (state_q == ST_TI || state_q == ST_T4) &&
                status_q == S_PASSIVE) begin
                status_d     = cmd_status_q;
                address_d    = cmd_address_q;
                cyc_status_d = cmd_status_q;
            end
            // READY sample. HALT never waits; the limit forces completion
            // and is only reported as a timeout when READY did not arrive.
            if (state_q == ST_T3 || state_q == ST_TW) begin
                go_now    = ready | cyc_halt | tw_limit;
                forced    = tw_limit & ~ready & ~cyc_halt;
                go_d      = go_now;
                timeout_d = forced;
                if (go_now) begin
                    status_d = S_PASSIVE;
                end
            end
        end

        if (neg) begin
            case (state_q)
                ST_TI: begin
                    if (status_q != S_PASSIVE) begin
                        state_d    = ST_T1;
                        tw_count_d = '0;
                    end
                end
                ST_T1: begin
                    state_d = ST_T2;
                    if (cyc_write) begin
                        data_out_d = cmd_wdata_q;
                        doe_d      = 1'b1;
                    end
                end
                ST_T2: begin
                    state_d = ST_T3;
                end
                ST_T3, ST_TW: begin
                    if (go_q) begin
                        state_d       = ST_T4;
                        cmd_valid_d   = 1'b0;
                        done_d        = 1'b1;
                        bus_timeout_d = timeout_q;
                        if (cyc_read) begin
                            rdata_d = data_in;
                        end
                    end else begin
                        state_d = ST_TW;
                        if (tw_count_q != {TW_W{1'b1}}) begin
                            tw_count_d = tw_count_q + TW_W'(1);
                        end
                    end
                end
                ST_T4: begin
                    doe_d = 1'b0;
                    // A launch during T4 chains straight into the next T1.
                    if (status_q != S_PASSIVE) begin
                        state_d    = ST_T1;
                        tw_count_d = '0;
                    end else begin
                        state_d = ST_TI;
                    end
                end
                default: begin
                    state_d = ST_TI;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_clock_q   <= 1'b0;
            state_q       <= ST_TI;
            cmd_valid_q   <= 1'b0;
            cmd_status_q  <= S_PASSIVE;
            cmd_address_q <= '0;
            cmd_wdata_q   <= '0;
            cyc_status_q  <= S_PASSIVE;
            status_q      <= S_PASSIVE;
            address_q     <= '0;
            data_out_q    <= '0;
            doe_q         <= 1'b0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            bus_timeout_q <= 1'b0;
            go_q          <= 1'b0;
            timeout_q     <= 1'b0;
            tw_count_q    <= '0;
        end else begin
            cpu_clock_q   <= cpu_clock;
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_status_q  <= cmd_status_d;
            cmd_address_q <= cmd_address_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cyc_status_q  <= cyc_status_d;
            status_q      <= status_d;
            address_q     <= address_d;
            data_out_q    <= data_out_d;
            doe_q         <= doe_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            bus_timeout_q <= bus_timeout_d;
            go_q          <= go_d;
            timeout_q     <= timeout_d;
            tw_count_q    <= tw_count_d;
        end
    end

    assign done             = done_q;
    assign rdata            = rdata_q;
    assign bus_timeout      = bus_timeout_q;
    assign processor_status = status_q;
    assign address          = address_q;
    assign data_out         = data_out_q;
    assign data_out_enable  = doe_q;

endmodule
